// File: rtl/nanorv32_div_iter.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Runs one quotient bit per cycle on operand magnitudes and fixes the signs when it loads the result.
module nanorv32_div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_in_1_signed,
  input  logic             req_in_2_signed,
  input  logic             rem_op_sel,
  input  logic [WIDTH-1:0] req_in_1,
  input  logic [WIDTH-1:0] req_in_2,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;
  logic [CNT_W-1:0] cnt_r;
  logic             neg_quo;
  logic             neg_rem;
  logic             rem_sel;
  logic [WIDTH-1:0] result_r;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return WIDTH'(0) - x;
  endfunction

  // Request decode and operand magnitudes.
  logic             accept;
  logic             sign_1;
  logic             sign_2;
  logic [WIDTH-1:0] mag_1;
  logic [WIDTH-1:0] mag_2;
  logic             div_zero;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign resp_result = result_r;

  assign accept   = req_valid & req_ready;
  assign sign_1   = req_in_1_signed & req_in_1[WIDTH-1];
  assign sign_2   = req_in_2_signed & req_in_2[WIDTH-1];
  assign mag_1    = sign_1 ? negate(req_in_1) : req_in_1;
  assign mag_2    = sign_2 ? negate(req_in_2) : req_in_2;
  assign div_zero = (req_in_2 == '0);

  // One restoring step: shift {rem, quo} left, try subtracting the divisor
  // one bit wider so the borrow lands in the top bit.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             take;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] result_step;
  logic             last_step;

  assign rem_shift = {rem_r, quo_r[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvs_r};
  assign take      = ~trial[WIDTH];
  assign rem_step  = take ? trial[WIDTH-1:0] : {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
  assign quo_step  = {quo_r[WIDTH-2:0], take};
  assign last_step = (cnt_r == '0);

  always_comb begin
    result_step = '0;
    if (rem_sel) begin
      result_step = neg_rem ? negate(rem_step) : rem_step;
    end else begin
      result_step = neg_quo ? negate(quo_step) : quo_step;
    end
  end

  // NOTE: registers use non-blocking assignments only; next-state logic lives
  // in always_comb with a default first so no latch is inferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = div_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the datapath is a handful of flops, not a memory, so every register
  // gets a reset value; an aborted request then leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r    <= '0;
      quo_r    <= '0;
      dvs_r    <= '0;
      cnt_r    <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      rem_sel  <= 1'b0;
      result_r <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            rem_r   <= '0;
            quo_r   <= mag_1;
            dvs_r   <= mag_2;
            cnt_r   <= CNT_W'(WIDTH - 1);
            neg_quo <= sign_1 ^ sign_2;
            neg_rem <= sign_1;
            rem_sel <= rem_op_sel;
            // Divide-by-zero skips the iterations: RISC-V defines the result.
            if (div_zero) begin
              result_r <= rem_op_sel ? req_in_1 : '1;
            end
          end
        end
        BUSY: begin
          rem_r <= rem_step;
          quo_r <= quo_step;
          if (last_step) begin
            result_r <= result_step;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
